decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the in-order RV64I core. Consumes the fetch latch (DE_NPC, DE_PC, DE_IR, DE_V) and decodes the instruction. Reads source operands from the external register file, and tracks outstanding register writes in a scoreboard. Drives the fetch-side stalls V_DEP_STALL and V_DE_FE_BR_STALL, and registers a decoded bundle into the EXE latch.

## Interface
Parameters:
- XLEN, 64, datapath/PC width
- NREG, 32, architectural registers (x0 hardwired zero)

Ports:
- CLK  in  1  rising-edge clock, the only clock
- RESET_N  in  1  synchronous, active-low reset
- DE_NPC  in  XLEN  PC+4 from fetch latch
- DE_PC  in  XLEN  PC from fetch latch
- DE_IR  in  32  instruction from fetch latch
- DE_V  in  1  fetch latch valid
- RF_SR1_ADDR  out  5  regfile read port 1 address (IR[19:15]), combinational
- RF_SR2_ADDR  out  5  regfile read port 2 address (IR[24:20]), combinational
- RF_SR1_DATA  in  XLEN  read data 1, combinational from regfile
- RF_SR2_DATA  in  XLEN  read data 2
- WB_V  in  1  writeback retiring a register write this cycle
- WB_DR  in  5  writeback destination
- V_DEP_STALL  out  1  RAW hazard; holds fetch PC and fetch latch, combinational
- V_DE_FE_BR_STALL  out  1  control instruction in decode, combinational
- EXE_V, EXE_PC, EXE_NPC, EXE_IR  out  1/XLEN/XLEN/32  registered pass-through
- EXE_SR1, EXE_SR2  out  XLEN  registered operand values (0 when source is x0)
- EXE_IMM  out  XLEN  sign-extended immediate
- EXE_DR  out  5  destination register
- EXE_RF_WE  out  1  instruction writes DR (0 when DR = x0)
- EXE_ILLEGAL  out  1  unrecognised opcode

## Operation
- Formats by opcode IR[6:0]:
  - R (0110011, 0111011): sources rs1, rs2; writes rd.
  - I (0010011, 0011011, 0000011, 1100111): source rs1; writes rd.
  - S (0100011): sources rs1, rs2; no write.
  - B (1100011): sources rs1, rs2; no write.
  - U (0110111, 0010111): no sources; writes rd.
  - J (1101111): no sources; writes rd.
- Any other opcode: EXE_ILLEGAL=1, no sources, no write, still issues.
- Immediate:
  - I: IR[31:20].
  - S: {IR[31:25], IR[11:7]}.
  - B: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - U: {IR[31:12], 12'b0}.
  - J: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - All formats sign-extend from their top bit to XLEN. R format gives 0.
- Scoreboard: NREG pending bits; bit 0 is always 0.
- V_DEP_STALL = DE_V & (a used source register, not x0, has its pending bit set). Pending bits are registered; a same-cycle WB clear does not release the stall, which drops the following cycle.
- V_DE_FE_BR_STALL = DE_V & opcode ∈ {1100011, 1101111, 1100111} & !V_DEP_STALL.
- Issue = DE_V & !V_DEP_STALL. On issue, the bundle latches into EXE with EXE_V=1. If EXE_RF_WE, pending[rd] is set.
- No issue (invalid or stalled): EXE_V<=0. Other EXE fields are don't-care but hold their previous values. The scoreboard is not set.
- A WB_V clear of pending[WB_DR] and an issue set of the same register in the same cycle: set wins.
- WB_V with WB_DR=0 is ignored.

## Timing
- Decode-to-EXE latency: 1 cycle. Stall outputs are combinational from the DE_* inputs and the scoreboard in the same cycle.
- While V_DEP_STALL=1, fetch holds DE_*; this stage re-evaluates every cycle until the hazard clears.
- Reset (RESET_N=0 at an edge), including mid-stall:
  - All pending bits are 0.
  - EXE_V=0, EXE_RF_WE=0, EXE_ILLEGAL=0.
  - EXE_PC, EXE_NPC, EXE_IR, EXE_SR1, EXE_SR2, EXE_IMM and EXE_DR are 0.
  - Stall outputs follow the inputs combinationally: both are 0 while DE_V=0.

## Structure
- Shared package riscv_pkg:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_REG, OP_REG32);
  - immediate-format enum imm_fmt_t;
  - XLEN.
- Sub-module decode_scoreboard: pending-bit array with set port, clear port, set-wins priority, two read ports and synchronous active-low reset.

## Test plan
- After reset, DE_V=1, IR=0x00500093 (addi x1,x0,5) → next cycle EXE_V=1, EXE_DR=1, EXE_IMM=5, EXE_SR1=0, EXE_RF_WE=1. V_DEP_STALL=0 throughout.
- addi x1 issued, then IR=0x00108133 (add x2,x1,x1) → V_DEP_STALL=1 and EXE_V=0 each cycle. WB_V=1, WB_DR=1 at cycle N → stall drops at N+1 and the add issues at N+2's edge.
- IR=0xFE000EE3 (beq x0,x0,-4) → V_DE_FE_BR_STALL=1 the same cycle. EXE_IMM=0xFFFF_FFFF_FFFF_FFFC.
- IR=0x800000B7 (lui x1,0x80000) → EXE_IMM=0xFFFF_FFFF_8000_0000.
- Same-cycle WB clear of x3 and issue of an instruction writing x3 → pending[3] stays 1, and a following reader of x3 stalls.
- RESET_N=0 during an active stall with pending bits set → EXE_V=0 and the scoreboard is empty. The held instruction issues in the first cycle after reset deasserts.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions: opcodes, immediate formats and the opcode
// classification helpers used by the decode stage.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        imm_fmt_t fmt;
        logic     use_rs1;
        logic     use_rs2;
        logic     writes_rd;
        logic     is_ctrl;
        logic     illegal;
    } decode_t;

    function automatic decode_t decode_opcode(input logic [6:0] op);
        decode_t d;
        d.fmt       = IMM_R;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.writes_rd = 1'b0;
        d.is_ctrl   = 1'b0;
        d.illegal   = 1'b0;
        case (op)
            OP_REG, OP_REG32: begin
                d.use_rs1   = 1'b1;
                d.use_rs2   = 1'b1;
                d.writes_rd = 1'b1;
            end
            OP_IMM, OP_IMM32, OP_LOAD: begin
                d.fmt       = IMM_I;
                d.use_rs1   = 1'b1;
                d.writes_rd = 1'b1;
            end
            OP_JALR: begin
                d.fmt       = IMM_I;
                d.use_rs1   = 1'b1;
                d.writes_rd = 1'b1;
                d.is_ctrl   = 1'b1;
            end
            OP_STORE: begin
                d.fmt     = IMM_S;
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                d.fmt     = IMM_B;
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.is_ctrl = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt       = IMM_U;
                d.writes_rd = 1'b1;
            end
            OP_JAL: begin
                d.fmt       = IMM_J;
                d.writes_rd = 1'b1;
                d.is_ctrl   = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // 32-bit sign-extended immediate; callers widen to their XLEN.
    function automatic logic [31:0] build_imm32(input imm_fmt_t fmt, input logic [31:0] ir);
        case (fmt)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   return {ir[31:12], 12'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between the decode stage and its neighbours: fetch latch, register file,
// writeback and the EXE latch. The stage itself uses the slave modport.
interface decode_stage_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic [XLEN-1:0] DE_NPC;
    logic [XLEN-1:0] DE_PC;
    logic [31:0]     DE_IR;
    logic            DE_V;

    logic [4:0]      RF_SR1_ADDR;
    logic [4:0]      RF_SR2_ADDR;
    logic [XLEN-1:0] RF_SR1_DATA;
    logic [XLEN-1:0] RF_SR2_DATA;

    logic            WB_V;
    logic [4:0]      WB_DR;

    logic            V_DEP_STALL;
    logic            V_DE_FE_BR_STALL;

    logic            EXE_V;
    logic [XLEN-1:0] EXE_PC;
    logic [XLEN-1:0] EXE_NPC;
    logic [31:0]     EXE_IR;
    logic [XLEN-1:0] EXE_SR1;
    logic [XLEN-1:0] EXE_SR2;
    logic [XLEN-1:0] EXE_IMM;
    logic [4:0]      EXE_DR;
    logic            EXE_RF_WE;
    logic            EXE_ILLEGAL;

    modport master (
        output DE_NPC, DE_PC, DE_IR, DE_V,
        output RF_SR1_DATA, RF_SR2_DATA,
        output WB_V, WB_DR,
        input  RF_SR1_ADDR, RF_SR2_ADDR,
        input  V_DEP_STALL, V_DE_FE_BR_STALL,
        input  EXE_V, EXE_PC, EXE_NPC, EXE_IR, EXE_SR1, EXE_SR2,
        input  EXE_IMM, EXE_DR, EXE_RF_WE, EXE_ILLEGAL
    );

    modport slave (
        input  DE_NPC, DE_PC, DE_IR, DE_V,
        input  RF_SR1_DATA, RF_SR2_DATA,
        input  WB_V, WB_DR,
        output RF_SR1_ADDR, RF_SR2_ADDR,
        output V_DEP_STALL, V_DE_FE_BR_STALL,
        output EXE_V, EXE_PC, EXE_NPC, EXE_IR, EXE_SR1, EXE_SR2,
        output EXE_IMM, EXE_DR, EXE_RF_WE, EXE_ILLEGAL
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback. Register 0 never reads as pending.
module decode_scoreboard #(
    parameter int unsigned NREG = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rd_addr_a,
    input  logic [4:0] rd_addr_b,
    output logic       rd_pend_a,
    output logic       rd_pend_b
);
    import riscv_pkg::*;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;

    // Set takes priority over a same-cycle clear of the same register.
    always_comb begin
        pend_next    = pend;
        pend_next[0] = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (set_en && set_addr == REG_AW'(i)) begin
                pend_next[i] = 1'b1;
            end else if (clr_en && clr_addr == REG_AW'(i)) begin
                pend_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    assign rd_pend_a = pend[rd_addr_a];
    assign rd_pend_b = pend[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: classifies the fetched instruction, reads operands,
// detects RAW hazards against the scoreboard and registers the EXE bundle.
module decode_stage #(
    parameter int unsigned XLEN = riscv_pkg::XLEN,
    parameter int unsigned NREG = 32
) (
    input logic           CLK,
    input logic           RESET_N,
    decode_stage_if.slave io
);
    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    decode_t         dec;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            pend1;
    logic            pend2;
    logic            hazard1;
    logic            hazard2;
    logic            dep_stall;
    logic            issue;
    logic            rf_we;
    logic [XLEN-1:0] sr1_val;
    logic [XLEN-1:0] sr2_val;

    assign opcode = io.DE_IR[6:0];
    assign rs1    = io.DE_IR[19:15];
    assign rs2    = io.DE_IR[24:20];
    assign rd     = io.DE_IR[11:7];

    assign dec   = decode_opcode(opcode);
    assign imm32 = build_imm32(dec.fmt, io.DE_IR);
    assign imm   = {{(XLEN-32){imm32[31]}}, imm32};

    assign io.RF_SR1_ADDR = rs1;
    assign io.RF_SR2_ADDR = rs2;

    decode_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .set_en    (issue & rf_we),
        .set_addr  (rd),
        .clr_en    (io.WB_V),
        .clr_addr  (io.WB_DR),
        .rd_addr_a (rs1),
        .rd_addr_b (rs2),
        .rd_pend_a (pend1),
        .rd_pend_b (pend2)
    );

    // Pending bits are registered, so a writeback in this cycle cannot release the stall.
    assign hazard1   = dec.use_rs1 & (rs1 != '0) & pend1;
    assign hazard2   = dec.use_rs2 & (rs2 != '0) & pend2;
    assign dep_stall = io.DE_V & (hazard1 | hazard2);
    assign issue     = io.DE_V & ~dep_stall;
    assign rf_we     = dec.writes_rd & (rd != '0);

    assign io.V_DEP_STALL      = dep_stall;
    assign io.V_DE_FE_BR_STALL = io.DE_V & dec.is_ctrl & ~dep_stall;

    assign sr1_val = (dec.use_rs1 && rs1 != '0) ? io.RF_SR1_DATA : '0;
    assign sr2_val = (dec.use_rs2 && rs2 != '0) ? io.RF_SR2_DATA : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            io.EXE_V       <= 1'b0;
            io.EXE_PC      <= '0;
            io.EXE_NPC     <= '0;
            io.EXE_IR      <= '0;
            io.EXE_SR1     <= '0;
            io.EXE_SR2     <= '0;
            io.EXE_IMM     <= '0;
            io.EXE_DR      <= '0;
            io.EXE_RF_WE   <= 1'b0;
            io.EXE_ILLEGAL <= 1'b0;
        end else begin
            io.EXE_V <= issue;
            if (issue) begin
                io.EXE_PC      <= io.DE_PC;
                io.EXE_NPC     <= io.DE_NPC;
                io.EXE_IR      <= io.DE_IR;
                io.EXE_SR1     <= sr1_val;
                io.EXE_SR2     <= sr2_val;
                io.EXE_IMM     <= imm;
                io.EXE_DR      <= dec.writes_rd ? rd : '0;
                io.EXE_RF_WE   <= rf_we;
                io.EXE_ILLEGAL <= dec.illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a per-cycle behavioural model of the
// scoreboard and EXE latch plus hand-computed spot checks.
module tb_decode_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(64)) bus ();

    decode_stage #(
        .XLEN(64),
        .NREG(32)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .io      (bus)
    );

    // Register file contents are a fixed function of the address (x0 deliberately non-zero).
    function automatic logic [63:0] rf_val(input logic [4:0] a);
        return {8'hA5, 51'd0, a};
    endfunction

    assign bus.RF_SR1_DATA = rf_val(bus.RF_SR1_ADDR);
    assign bus.RF_SR2_DATA = rf_val(bus.RF_SR2_ADDR);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          u1;
        bit          u2;
        bit          wr;
        bit          ctrl;
        bit          ill;
        logic [63:0] imm;
    } mdec_t;

    function automatic mdec_t mdec(input logic [31:0] ir);
        mdec_t       d;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [31:0] u32;
        d.u1 = 0; d.u2 = 0; d.wr = 0; d.ctrl = 0; d.ill = 0; d.imm = '0;
        i12 = {ir[31:25], ir[11:7]};
        b13 = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        j21 = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        u32 = {ir[31:12], 12'h000};
        case (ir[6:0])
            7'b0110011, 7'b0111011: begin d.u1 = 1; d.u2 = 1; d.wr = 1; end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                d.u1 = 1; d.wr = 1;
                d.ctrl = (ir[6:0] == 7'b1100111);
                d.imm = 64'($signed(ir[31:20]));
            end
            7'b0100011: begin d.u1 = 1; d.u2 = 1; d.imm = 64'($signed(i12)); end
            7'b1100011: begin d.u1 = 1; d.u2 = 1; d.ctrl = 1; d.imm = 64'($signed(b13)); end
            7'b0110111, 7'b0010111: begin d.wr = 1; d.imm = 64'($signed(u32)); end
            7'b1101111: begin d.wr = 1; d.ctrl = 1; d.imm = 64'($signed(j21)); end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic logic m_stall(input logic v, input logic [31:0] ir, input logic [31:0] pend);
        mdec_t d;
        d = mdec(ir);
        return v && ((d.u1 && ir[19:15] != 0 && pend[ir[19:15]]) ||
                     (d.u2 && ir[24:20] != 0 && pend[ir[24:20]]));
    endfunction

    function automatic logic m_br(input logic v, input logic [31:0] ir, input logic [31:0] pend);
        mdec_t d;
        d = mdec(ir);
        return v && d.ctrl && !m_stall(v, ir, pend);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pend, input logic issue,
                                           input logic [31:0] ir, input logic wbv, input logic [4:0] wbdr);
        logic [31:0] p;
        mdec_t       d;
        p = pend;
        d = mdec(ir);
        if (wbv && wbdr != 0) p[wbdr] = 1'b0;
        if (issue && d.wr && ir[11:7] != 0) p[ir[11:7]] = 1'b1;
        return p;
    endfunction

    function automatic logic [63:0] m_src(input bit used, input logic [4:0] r);
        return (used && r != 0) ? rf_val(r) : 64'd0;
    endfunction

    function automatic mdec_t mdec_of(input logic [31:0] ir);
        return mdec(ir);
    endfunction

    logic [31:0] mpend;
    logic        mready = 1'b0;
    logic        e_v, e_we, e_ill;
    logic [63:0] e_pc, e_npc, e_sr1, e_sr2, e_imm;
    logic [31:0] e_ir;
    logic [4:0]  e_dr;
    bit          c_sr1, c_sr2, c_dr;

    always @(posedge clk) begin
        mready <= 1'b1;
        if (!rst_n) begin
            mpend <= '0;
            e_v <= 0; e_we <= 0; e_ill <= 0;
            e_pc <= '0; e_npc <= '0; e_ir <= '0; e_sr1 <= '0; e_sr2 <= '0; e_imm <= '0; e_dr <= '0;
            c_sr1 <= 1; c_sr2 <= 1; c_dr <= 1;
        end else begin
            mpend <= m_next(mpend, bus.DE_V && !m_stall(bus.DE_V, bus.DE_IR, mpend),
                            bus.DE_IR, bus.WB_V, bus.WB_DR);
            e_v <= bus.DE_V && !m_stall(bus.DE_V, bus.DE_IR, mpend);
            if (bus.DE_V && !m_stall(bus.DE_V, bus.DE_IR, mpend)) begin
                e_pc  <= bus.DE_PC;
                e_npc <= bus.DE_NPC;
                e_ir  <= bus.DE_IR;
                e_imm <= mdec_of(bus.DE_IR).imm;
                e_we  <= mdec_of(bus.DE_IR).wr && bus.DE_IR[11:7] != 0;
                e_ill <= mdec_of(bus.DE_IR).ill;
                e_dr  <= bus.DE_IR[11:7];
                c_dr  <= mdec_of(bus.DE_IR).wr;
                e_sr1 <= m_src(mdec_of(bus.DE_IR).u1, bus.DE_IR[19:15]);
                e_sr2 <= m_src(mdec_of(bus.DE_IR).u2, bus.DE_IR[24:20]);
                c_sr1 <= mdec_of(bus.DE_IR).u1;
                c_sr2 <= mdec_of(bus.DE_IR).u2;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mready) begin
            chk("dep_stall", bus.V_DEP_STALL, m_stall(bus.DE_V, bus.DE_IR, mpend));
            chk("br_stall", bus.V_DE_FE_BR_STALL, m_br(bus.DE_V, bus.DE_IR, mpend));
            chk("sr1_addr", bus.RF_SR1_ADDR, bus.DE_IR[19:15]);
            chk("sr2_addr", bus.RF_SR2_ADDR, bus.DE_IR[24:20]);
            chk("exe_v", bus.EXE_V, e_v);
            chk("exe_pc", bus.EXE_PC, e_pc);
            chk("exe_npc", bus.EXE_NPC, e_npc);
            chk("exe_ir", bus.EXE_IR, e_ir);
            chk("exe_imm", bus.EXE_IMM, e_imm);
            chk("exe_we", bus.EXE_RF_WE, e_we);
            chk("exe_ill", bus.EXE_ILLEGAL, e_ill);
            if (c_dr) chk("exe_dr", bus.EXE_DR, e_dr);
            if (c_sr1) chk("exe_sr1", bus.EXE_SR1, e_sr1);
            if (c_sr2) chk("exe_sr2", bus.EXE_SR2, e_sr2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] pc);
        bus.DE_V   = v;
        bus.DE_IR  = ir;
        bus.DE_PC  = pc;
        bus.DE_NPC = pc + 64'd4;
    endtask

    initial begin
        bus.WB_V  = 1'b0;
        bus.WB_DR = 5'd0;
        drive(1'b0, 32'h0, 64'h0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("rst_exe_v", bus.EXE_V, 0);
        chk("rst_exe_pc", bus.EXE_PC, 0);
        chk("rst_dep", bus.V_DEP_STALL, 0);

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 64'h1000);
        #1 chk("addi_dep", bus.V_DEP_STALL, 0);
        tick(1);
        chk("addi_v", bus.EXE_V, 1);
        chk("addi_dr", bus.EXE_DR, 1);
        chk("addi_imm", bus.EXE_IMM, 5);
        chk("addi_sr1", bus.EXE_SR1, 0);
        chk("addi_we", bus.EXE_RF_WE, 1);

        // add x2,x1,x1 waits on x1
        drive(1'b1, 32'h00108133, 64'h1004);
        #1 chk("add_dep0", bus.V_DEP_STALL, 1);
        tick(1);
        chk("add_stall_v0", bus.EXE_V, 0);
        tick(1);
        chk("add_stall_v1", bus.EXE_V, 0);
        bus.WB_V  = 1'b1;
        bus.WB_DR = 5'd1;
        #1 chk("add_dep_wb_cycle", bus.V_DEP_STALL, 1);
        tick(1);
        bus.WB_V = 1'b0;
        #1 chk("add_dep_released", bus.V_DEP_STALL, 0);
        chk("add_not_yet_v", bus.EXE_V, 0);
        tick(1);
        chk("add_v", bus.EXE_V, 1);
        chk("add_ir", bus.EXE_IR, 32'h00108133);
        chk("add_sr1", bus.EXE_SR1, 64'hA500_0000_0000_0001);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 64'h1008);
        #1 chk("beq_br", bus.V_DE_FE_BR_STALL, 1);
        tick(1);
        chk("beq_imm", bus.EXE_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_we", bus.EXE_RF_WE, 0);

        // lui x1,0x80000
        drive(1'b1, 32'h800000B7, 64'h100C);
        tick(1);
        chk("lui_imm", bus.EXE_IMM, 64'hFFFF_FFFF_8000_0000);
        chk("lui_dr", bus.EXE_DR, 1);

        // sd x0,-8(x0)
        drive(1'b1, 32'hFE003C23, 64'h1010);
        tick(1);
        chk("sd_imm", bus.EXE_IMM, 64'hFFFF_FFFF_FFFF_FFF8);

        // jal x0,+8
        drive(1'b1, 32'h0080006F, 64'h1014);
        #1 chk("jal_br", bus.V_DE_FE_BR_STALL, 1);
        tick(1);
        chk("jal_imm", bus.EXE_IMM, 8);
        chk("jal_we", bus.EXE_RF_WE, 0);

        // illegal opcode, with a writeback to x0 that must be ignored
        drive(1'b1, 32'hFFFFFFFF, 64'h1018);
        bus.WB_V  = 1'b1;
        bus.WB_DR = 5'd0;
        tick(1);
        bus.WB_V = 1'b0;
        chk("ill_flag", bus.EXE_ILLEGAL, 1);
        chk("ill_v", bus.EXE_V, 1);

        // addi x3,x0,1 then addi x3,x0,2 alongside a writeback of x3: set wins
        drive(1'b1, 32'h00100193, 64'h101C);
        tick(1);
        drive(1'b1, 32'h00200193, 64'h1020);
        bus.WB_V  = 1'b1;
        bus.WB_DR = 5'd3;
        tick(1);
        bus.WB_V = 1'b0;
        chk("x3_second_imm", bus.EXE_IMM, 2);

        // add x4,x3,x0 must stall on the still-pending x3
        drive(1'b1, 32'h00018233, 64'h1024);
        #1 chk("x3_reader_dep", bus.V_DEP_STALL, 1);
        tick(2);
        chk("x3_reader_v", bus.EXE_V, 0);

        // reset in the middle of the stall
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_v", bus.EXE_V, 0);
        chk("mid_rst_ir", bus.EXE_IR, 0);
        chk("mid_rst_dep", bus.V_DEP_STALL, 0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_v", bus.EXE_V, 1);
        chk("post_rst_ir", bus.EXE_IR, 32'h00018233);
        chk("post_rst_sr1", bus.EXE_SR1, 64'hA500_0000_0000_0003);

        drive(1'b0, 32'h0, 64'h0);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
